// File: rtl/param_sum_pkg.sv
// Shared types and constant-width helpers for the parameterised summing engine.
package param_sum_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Ceiling log2; clog2(1) = 0.
  function automatic int unsigned clog2(input int unsigned x);
    int unsigned r;
    int unsigned v;
    r = 0;
    v = 1;
    while (v < x) begin
      v = v << 1;
      r = r + 1;
    end
    return r;
  endfunction

  // Width needed to hold the sum of n unsigned w-bit values.
  function automatic int unsigned sum_width(input int unsigned n, input int unsigned w);
    return w + clog2(n);
  endfunction

endpackage

// File: rtl/param_sum_add.sv
// OUT_W-bit adder with carry-out; saturates to all-ones when PARAM_SUM_SAT_EN is defined.
module param_sum_add #(
  parameter int unsigned W = 34
) (
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  output logic [W-1:0] o_sum_c,
  output logic         o_carry_c
);

  logic [W:0] w_full;

  assign w_full    = {1'b0, i_a} + {1'b0, i_b};
  assign o_carry_c = w_full[W];

`ifdef PARAM_SUM_SAT_EN
  // A saturated accumulator stays at all-ones: any further non-zero add carries again.
  assign o_sum_c = w_full[W] ? {W{1'b1}} : w_full[W-1:0];
`else
  assign o_sum_c = w_full[W-1:0];
`endif

endmodule

// File: rtl/param_sum_engine.sv
// Sequential summer: one element per cycle over the first min(count, N) operands.
// Optional saturation is selected with the PARAM_SUM_SAT_EN macro (see param_sum_add).
module param_sum_engine
  import param_sum_pkg::*;
#(
  parameter int unsigned N     = 4,
  parameter int unsigned W     = 32,
  parameter int unsigned OUT_W = sum_width(N, W)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [N-1:0][W-1:0]       values,
  input  logic [clog2(N+1)-1:0]     count,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [OUT_W-1:0]          sum,
  output logic                      ovf
);

  localparam int unsigned CNT_W = clog2(N + 1);

  state_e              r_state;
  logic [N-1:0][W-1:0] r_vals;
  logic [CNT_W-1:0]    r_cnt;
  logic [CNT_W-1:0]    r_idx;
  logic [OUT_W-1:0]    r_acc;
  logic [OUT_W-1:0]    r_sum;
  logic                r_ovf_acc;
  logic                r_ovf;
  logic                r_in_ready;
  logic                r_out_valid;

  logic [CNT_W-1:0]    w_cnt_eff;
  logic [OUT_W-1:0]    w_elem;
  logic [OUT_W-1:0]    w_add_sum;
  logic                w_add_carry;

  assign w_cnt_eff = (count > CNT_W'(N)) ? CNT_W'(N) : count;
  // Captured operands shift down each cycle, so the current element is always slot 0.
  assign w_elem    = OUT_W'(r_vals[0]);

  param_sum_add #(.W(OUT_W)) u_add (
    .i_a       (r_acc),
    .i_b       (w_elem),
    .o_sum_c   (w_add_sum),
    .o_carry_c (w_add_carry)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_vals      <= '0;
      r_cnt       <= '0;
      r_idx       <= '0;
      r_acc       <= '0;
      r_sum       <= '0;
      r_ovf_acc   <= 1'b0;
      r_ovf       <= 1'b0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid && r_in_ready) begin
            r_vals     <= values;
            r_cnt      <= w_cnt_eff;
            r_idx      <= '0;
            r_acc      <= '0;
            r_ovf_acc  <= 1'b0;
            r_in_ready <= 1'b0;
            if (w_cnt_eff == '0) begin
              r_state     <= DONE;
              r_out_valid <= 1'b1;
              r_sum       <= '0;
              r_ovf       <= 1'b0;
            end else begin
              r_state <= ACC;
            end
          end
        end
        ACC: begin
          r_acc     <= w_add_sum;
          r_ovf_acc <= r_ovf_acc | w_add_carry;
          r_idx     <= r_idx + CNT_W'(1);
          r_vals    <= r_vals >> W;
          if (r_idx == (r_cnt - CNT_W'(1))) begin
            r_state     <= DONE;
            r_out_valid <= 1'b1;
            r_sum       <= w_add_sum;
            r_ovf       <= r_ovf_acc | w_add_carry;
          end
        end
        DONE: begin
          if (out_ready) begin
            r_state     <= IDLE;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
          end
        end
        default: begin
          r_state     <= IDLE;
          r_out_valid <= 1'b0;
          r_in_ready  <= 1'b1;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign sum       = r_sum;
  assign ovf       = r_ovf;

endmodule

// File: tb/tb_param_sum_engine.sv
// Scoreboard bench: a default-width engine and an OUT_W=8 engine share one request stream.
module tb_param_sum_engine;

  localparam int unsigned N  = 4;
  localparam int unsigned W  = 32;
  localparam int unsigned CW = 3;
`ifdef PARAM_SUM_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  typedef struct {
    logic [N-1:0][W-1:0] v;
    logic [CW-1:0]       c;
    logic [33:0]         sa;
    logic                oa;
    logic [7:0]          sb;
    logic                ob;
    int                  lat;
    bit                  stall;
  } vec_t;

  typedef struct {
    logic [33:0] s;
    logic        o;
    int          cyc;
  } exp_t;

  logic                clk = 1'b0;
  logic                rst;
  logic                in_valid;
  logic                out_ready;
  logic [N-1:0][W-1:0] values;
  logic [CW-1:0]       count;
  logic                in_ready_a, out_valid_a, ovf_a;
  logic [33:0]         sum_a;
  logic                in_ready_b, out_valid_b, ovf_b;
  logic [7:0]          sum_b;

  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   rst_chk_req = 0;
  int   rst_chk_done = 0;
  int   to_req = 0;
  int   to_done = 0;
  bit   pva = 1'b0;
  bit   pvb = 1'b0;
  exp_t qa[$];
  exp_t qb[$];
  vec_t vt[8];

  param_sum_engine #(.N(N), .W(W)) u_dut_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_a),
    .values(values), .count(count), .out_valid(out_valid_a),
    .out_ready(out_ready), .sum(sum_a), .ovf(ovf_a)
  );

  param_sum_engine #(.N(N), .W(W), .OUT_W(8)) u_dut_b (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_b),
    .values(values), .count(count), .out_valid(out_valid_b),
    .out_ready(out_ready), .sum(sum_b), .ovf(ovf_b)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [33:0] act, input logic [33:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every check in the bench happens here, away from the active edge.
  always @(negedge clk) begin
    exp_t e;
    if (to_req != to_done) begin
      to_done = to_done + 1;
      checks  = checks + 1;
      errors  = errors + 1;
      $display("FAIL timeout: bounded wait expired at cycle %0d, required a DUT response", cyc);
    end
    if (rst_chk_req != rst_chk_done) begin
      rst_chk_done = rst_chk_done + 1;
      check("rst_in_ready_a", 34'(in_ready_a), 34'd1);
      check("rst_out_valid_a", 34'(out_valid_a), 34'd0);
      check("rst_sum_a", sum_a, 34'd0);
      check("rst_ovf_a", 34'(ovf_a), 34'd0);
      check("rst_in_ready_b", 34'(in_ready_b), 34'd1);
      check("rst_out_valid_b", 34'(out_valid_b), 34'd0);
      check("rst_sum_b", 34'(sum_b), 34'd0);
    end
    if (!rst) begin
      if (out_valid_a) begin
        if (qa.size() == 0) check("spurious_valid_a", 34'(out_valid_a), 34'd0);
        else begin
          e = qa[0];
          if (!pva) check("latency_a", 34'(cyc), 34'(e.cyc));
          check("sum_a", sum_a, e.s);
          check("ovf_a", 34'(ovf_a), 34'(e.o));
          check("in_ready_done_a", 34'(in_ready_a), 34'd0);
          if (out_ready) void'(qa.pop_front());
        end
      end
      if (out_valid_b) begin
        if (qb.size() == 0) check("spurious_valid_b", 34'(out_valid_b), 34'd0);
        else begin
          e = qb[0];
          if (!pvb) check("latency_b", 34'(cyc), 34'(e.cyc));
          check("sum_b", 34'(sum_b), e.s);
          check("ovf_b", 34'(ovf_b), 34'(e.o));
          if (out_ready) void'(qb.pop_front());
        end
      end
    end
    pva = out_valid_a;
    pvb = out_valid_b;
  end

  task automatic send(input int k, input bit push);
    int  t;
    bit  ok;
    exp_t e;
    t  = 0;
    ok = 1'b0;
    @(negedge clk);
    values   = vt[k].v;
    count    = vt[k].c;
    in_valid = 1'b1;
    for (int i = 0; i < 100 && !ok; i++) begin
      if (in_ready_a && in_ready_b) begin
        ok = 1'b1;
        t  = cyc;
      end else @(negedge clk);
    end
    if (!ok) begin
      to_req   = to_req + 1;
      in_valid = 1'b0;
      return;
    end
    if (push) begin
      e.s = vt[k].sa;       e.o = vt[k].oa; e.cyc = t + vt[k].lat; qa.push_back(e);
      e.s = 34'(vt[k].sb);  e.o = vt[k].ob; e.cyc = t + vt[k].lat; qb.push_back(e);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    values   = '1;
  endtask

  task automatic wait_valid();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      if (out_valid_a) ok = 1'b1;
    end
    if (!ok) to_req = to_req + 1;
  endtask

  initial begin
    vt[0] = '{v: {32'd4, 32'd3, 32'd2, 32'd1}, c: 3'd4, sa: 34'd10, oa: 1'b0,
              sb: 8'd10, ob: 1'b0, lat: 5, stall: 1'b1};
    vt[1] = '{v: {32'd4, 32'd3, 32'd2, 32'd1}, c: 3'd0, sa: 34'd0, oa: 1'b0,
              sb: 8'd0, ob: 1'b0, lat: 1, stall: 1'b0};
    vt[2] = '{v: {32'd4, 32'd3, 32'd2, 32'd1}, c: 3'd7, sa: 34'd10, oa: 1'b0,
              sb: 8'd10, ob: 1'b0, lat: 5, stall: 1'b0};
    vt[3] = '{v: {32'd0, 32'd100, 32'd100, 32'd100}, c: 3'd3, sa: 34'd300, oa: 1'b0,
              sb: SAT ? 8'd255 : 8'd44, ob: 1'b1, lat: 4, stall: 1'b0};
    vt[4] = '{v: {32'd0, 32'd100, 32'd100, 32'd100}, c: 3'd4, sa: 34'd300, oa: 1'b0,
              sb: SAT ? 8'd255 : 8'd44, ob: 1'b1, lat: 5, stall: 1'b0};
    vt[5] = '{v: {32'd200, 32'd200, 32'd200, 32'd200}, c: 3'd4, sa: 34'd800, oa: 1'b0,
              sb: SAT ? 8'd255 : 8'd32, ob: 1'b1, lat: 5, stall: 1'b0};
    vt[6] = '{v: {32'd9, 32'd9, 32'd9, 32'd7}, c: 3'd1, sa: 34'd7, oa: 1'b0,
              sb: 8'd7, ob: 1'b0, lat: 2, stall: 1'b0};
    vt[7] = '{v: {32'd0, 32'd0, 32'd250, 32'd250}, c: 3'd2, sa: 34'd500, oa: 1'b0,
              sb: SAT ? 8'd255 : 8'd244, ob: 1'b1, lat: 3, stall: 1'b0};

    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    values    = '0;
    count     = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst_chk_req = rst_chk_req + 1;

    for (int k = 0; k < 8; k++) begin
      if (vt[k].stall) out_ready = 1'b0;
      send(k, 1'b1);
      if (vt[k].stall) begin
        wait_valid();
        repeat (3) @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    end

    // Abandon an operation mid-accumulation; no result may appear.
    send(0, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (8) @(negedge clk);
    rst_chk_req = rst_chk_req + 1;
    send(0, 1'b1);

    for (int i = 0; i < 200 && (qa.size() != 0 || qb.size() != 0); i++) @(negedge clk);
    if (qa.size() != 0 || qb.size() != 0) to_req = to_req + 1;
    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/param_sum_engine.md
PARAM_SUM_ENGINE -- requirements
Module: param_sum_engine

Interface
REQ-001 SHALL have parameter N, default 4: number of elements in the packed input vector.
REQ-002 SHALL have parameter W, default 32: width of each element.
REQ-003 SHALL have parameter OUT_W, default sum_width(N, W) = W + clog2(N), evaluated by a constant function: accumulator and result width.
REQ-004 SHALL have port clk, input, 1: the single clock; all state rises on posedge clk.
REQ-005 SHALL have port rst, input, 1: reset, asynchronous and active-high.
REQ-006 SHALL have port in_valid, input, 1: request present.
REQ-007 SHALL have port in_ready, output, 1: engine accepts a request.
REQ-008 SHALL have port values, input, [N-1:0][W-1:0]: operands; element i is values[i].
REQ-009 SHALL have port count, input, clog2(N+1): number of elements to sum, starting at index 0.
REQ-010 SHALL have port out_valid, output, 1: result present.
REQ-011 SHALL have port out_ready, input, 1: consumer accepts the result.
REQ-012 SHALL have port sum, output, OUT_W: result.
REQ-013 SHALL have port ovf, output, 1: a carry out of OUT_W bits occurred during this operation.

Function
REQ-014 SHALL implement FSM states IDLE, ACC and DONE.
REQ-015 SHALL assert in_ready only in IDLE; a request is accepted when in_valid and in_ready are both high.
REQ-016 On accept, SHALL capture values and min(count, N); elements are unsigned and zero-extended to OUT_W.
REQ-017 On accept with an effective count of 0, SHALL go to DONE with sum = 0 and ovf = 0.
REQ-018 On accept otherwise, SHALL go to ACC with acc = 0 and idx = 0.
REQ-019 In ACC, SHALL perform one addition per cycle, acc += values[idx] and idx++, and go to DONE after the addition at idx = count-1.
REQ-020 Latency: for an accept in cycle T, out_valid SHALL rise in cycle T+1+count, or T+1 when count is 0.
REQ-021 In DONE, SHALL hold out_valid, sum and ovf stable until out_ready is high, then return to IDLE on the next edge.
REQ-022 Back-to-back: a new request SHALL NOT be accepted in the same cycle as the result handoff; the earliest accept is the cycle after.
REQ-023 Inputs SHALL be ignored outside the accept cycle; changing values during ACC has no effect.
REQ-024 ovf SHALL be sticky for the operation and cleared on accept.
REQ-025 Outside DONE, out_valid SHALL be 0; sum and ovf SHALL keep their last values.

Reset
REQ-026 While rst is high, SHALL asynchronously force state = IDLE, acc = 0, idx = 0, sum = 0, ovf = 0, out_valid = 0 and in_ready = 1 (after release).
REQ-027 Reset during ACC or DONE SHALL abandon the operation; no result is emitted.

Configuration
REQ-028 With PARAM_SUM_SAT_EN defined, an overflowing addition SHALL clamp acc to 2^OUT_W-1 and hold it for the rest of the operation, with ovf = 1.
REQ-029 Without PARAM_SUM_SAT_EN, addition SHALL wrap modulo 2^OUT_W; ovf is still reported.

Structure
REQ-030 Package param_sum_pkg SHALL hold the state enum and the constant functions clog2 and sum_width.
REQ-031 The single sub-module param_sum_add SHALL implement an OUT_W adder with carry-out and the optional saturation.

Verification (N=4, W=32 unless stated)
REQ-032 values={4,3,2,1} (values[0]=1), count=4 -> out_valid at T+5, sum=10, ovf=0.
REQ-033 Same values, count=0 -> out_valid at T+1, sum=0; count=7 -> clamped to 4, sum=10.
REQ-034 OUT_W=8, values={0,100,100,100}, count=3 -> sum=44 with ovf=1 without the macro; sum=255 with ovf=1 with the macro.
REQ-035 out_ready held low for 3 cycles in DONE -> sum, ovf and out_valid stable; in_ready=0 throughout.
REQ-036 rst pulsed at T+2 of a count=4 operation -> out_valid never rises; in_ready=1 after release; the next request sums correctly.
